drain_m: RTL and testbench
==========================

DRAIN_M -- requirements
Module: drain_M

Interface
REQ-001 Parameter DIM, default 5, maximum matrix dimension (elements per row and per column).
REQ-002 Parameter DATA_W, default 8, signed element width in bits.
REQ-003 clk  input  1  single clock for all logic; rising-edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to capture a result matrix and drain it.
REQ-006 mat_in  input  DIM*DIM*DATA_W (200)  packed signed result matrix, row-major, element (0,0) in the MSB byte.
REQ-007 ovf_in  input  1  overflow flag accompanying mat_in.
REQ-008 size  input  2  active dimension: 00=2x2, 01=3x3, 10=4x4, 11=5x5.
REQ-009 m_valid  output  1  m_addr/m_data hold a valid element.
REQ-010 m_ready  input  1  sink accepts the element this cycle.
REQ-011 m_addr  output  5  linear index row*DIM+col of the element.
REQ-012 m_data  output  DATA_W  signed element value.
REQ-013 busy  output  1  high from the cycle after start acceptance until done.
REQ-014 done  output  1  one-cycle pulse after the last element is accepted.
REQ-015 ovf_out  output  1  latched copy of ovf_in, captured at start acceptance.

Function
REQ-016 Element (r,c) SHALL be taken from mat_in bits [199-40r-8c : 192-40r-8c].
REQ-017 The FSM SHALL have states IDLE, SEND and DONE.
REQ-018 IDLE: start=1 SHALL capture mat_in, ovf_in and size into registers, clear row/col to 0 and enter SEND on the next edge.
REQ-019 start SHALL be ignored in SEND and DONE; captured registers SHALL NOT change during a drain.
REQ-020 SEND: m_valid=1, m_addr=row*5+col and m_data=element(row,col) of the captured matrix, all driven from registers.
REQ-021 A transfer SHALL occur only on a cycle with m_valid=1 and m_ready=1.
REQ-022 On a transfer, col SHALL increment; at col=N-1 it SHALL wrap to 0 and row SHALL increment (N = size+2).
REQ-023 On the transfer of (N-1,N-1), the FSM SHALL enter DONE and m_valid SHALL be 0 on the next cycle.
REQ-024 While m_valid=1 and m_ready=0, m_valid, m_addr and m_data SHALL remain stable.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 Latency: start accepted at edge k SHALL produce m_valid=1 from cycle k+1; with m_ready held high, N*N elements SHALL transfer on consecutive cycles, and done SHALL be high N*N+1 cycles after start.
REQ-027 Elements outside the active NxN window SHALL never be emitted; addresses SHALL keep DIM=5 row stride.
REQ-028 ovf_out SHALL hold its value until the next accepted start.
REQ-029 busy SHALL be 1 in SEND and DONE, and 0 in IDLE.

Reset
REQ-030 rst=0 at a clock edge SHALL force IDLE, with m_valid=0, busy=0, done=0, ovf_out=0, m_addr=0, m_data=0, and row/col=0.
REQ-031 Reset during SEND SHALL abort the drain; no done pulse SHALL follow.
REQ-032 start sampled with rst=0 SHALL be ignored.

Structure
REQ-033 A shared package SHALL hold DIM, DATA_W, MAT_W=200, the size encoding and the FSM state encoding.
REQ-034 Element extraction SHALL be a combinational sub-module elem_sel_M (captured matrix, row, col -> element).
REQ-035 drain_M SHALL contain the FSM, the row/col counters and the capture registers.

Verification
REQ-036 Reset, then start with size=00, mat_in bytes 0x01,0x02 (row 0) and 0x06,0x07 (row 1), m_ready=1 -> addr/data 0/0x01, 1/0x02, 5/0x06, 6/0x07 on consecutive cycles, then done.
REQ-037 size=11, element (r,c)=r*5+c-12 (signed), m_ready=1 -> 25 transfers with addr 0..24 and data -12..12, done at cycle 26 after start.
REQ-038 size=01, m_ready toggling 1,0,0,1 -> data stable through stalls, exactly 9 transfers with addr 0,1,2,5,6,7,10,11,12.
REQ-039 ovf_in=1 at start, then start re-pulsed mid-drain with different mat_in -> ovf_out=1 and output data unchanged; mid-drain start ignored.
REQ-040 rst=0 during transfer 3 of a 4x4 drain -> m_valid=0 and busy=0 the next cycle, no done pulse, and a new start drains from addr 0.

Source files
------------

// File: rtl/drain_m_pkg.sv
// rtl/drain_m_pkg.sv - shared constants, size encoding and FSM states for the matrix drain
package drain_m_pkg;

  localparam int DIM    = 5;
  localparam int DATA_W = 8;
  localparam int MAT_W  = DIM * DIM * DATA_W;

  typedef enum logic [1:0] {
    SIZE_2X2 = 2'b00,
    SIZE_3X3 = 2'b01,
    SIZE_4X4 = 2'b10,
    SIZE_5X5 = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/drain_m_elem_sel.sv
// rtl/drain_m_elem_sel.sv - combinational pick of element (row,col) from a row-major packed matrix
module elem_sel_m #(
  parameter int DIM    = drain_m_pkg::DIM,
  parameter int DATA_W = drain_m_pkg::DATA_W
) (
  input  logic [DIM*DIM*DATA_W-1:0] mat,
  input  logic [2:0]                row,
  input  logic [2:0]                col,
  output logic [DATA_W-1:0]         elem
);

  logic [7:0]                lin;
  logic [11:0]               shamt;
  logic [DIM*DIM*DATA_W-1:0] shifted;

  // Element (0,0) sits in the MSBs, so shift the wanted element up to the top.
  assign lin     = 8'(row) * 8'(DIM) + 8'(col);
  assign shamt   = 12'(lin) * 12'(DATA_W);
  assign shifted = mat << shamt;
  assign elem    = shifted[DIM*DIM*DATA_W-1 -: DATA_W];

endmodule

// File: rtl/drain_m.sv
// rtl/drain_m.sv - captures a result matrix and streams its active NxN window element by element
module drain_m #(
  parameter int DIM    = drain_m_pkg::DIM,
  parameter int DATA_W = drain_m_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIM*DIM*DATA_W-1:0] mat_in,
  input  logic                      ovf_in,
  input  logic [1:0]                size,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [4:0]                m_addr,
  output logic [DATA_W-1:0]         m_data,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf_out
);

  import drain_m_pkg::*;

  state_t                    state, state_n;
  size_t                     size_q;
  logic [DIM*DIM*DATA_W-1:0] mat_q;
  logic [DIM*DIM*DATA_W-1:0] sel_mat;
  logic                      ovf_q;
  logic [2:0]                row, col, nxt_row, nxt_col, n_last;
  logic [DATA_W-1:0]         sel_elem;
  logic                      accept, xfer, last;

  assign n_last = 3'(size_q) + 3'd1;
  assign accept = (state == ST_IDLE) && start;
  assign xfer   = (state == ST_SEND) && m_ready;
  assign last   = xfer && (row == n_last) && (col == n_last);

  always_comb begin
    nxt_row = row;
    nxt_col = col + 3'd1;
    if (col == n_last) begin
      nxt_col = 3'd0;
      nxt_row = row + 3'd1;
    end
    if (state == ST_IDLE) begin
      nxt_row = 3'd0;
      nxt_col = 3'd0;
    end
  end

  // In IDLE the selector looks at the incoming matrix so (0,0) is ready on the first SEND cycle.
  assign sel_mat = (state == ST_IDLE) ? mat_in : mat_q;

  elem_sel_m #(.DIM(DIM), .DATA_W(DATA_W)) u_elem_sel (
    .mat  (sel_mat),
    .row  (nxt_row),
    .col  (nxt_col),
    .elem (sel_elem)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_SEND;
      ST_SEND: if (last)  state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mat_q  <= '0;
      ovf_q  <= 1'b0;
      size_q <= SIZE_2X2;
      row    <= 3'd0;
      col    <= 3'd0;
      m_addr <= 5'd0;
      m_data <= '0;
    end else if (accept) begin
      mat_q  <= mat_in;
      ovf_q  <= ovf_in;
      size_q <= size_t'(size);
      row    <= 3'd0;
      col    <= 3'd0;
      m_addr <= 5'd0;
      m_data <= sel_elem;
    end else if (xfer && !last) begin
      row    <= nxt_row;
      col    <= nxt_col;
      m_addr <= 5'(nxt_row) * 5'(DIM) + 5'(nxt_col);
      m_data <= sel_elem;
    end
  end

  assign m_valid = (state == ST_SEND);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign ovf_out = ovf_q;

endmodule

// File: tb/tb_drain_m.sv
// tb/tb_drain_m.sv - scoreboard bench for drain_m with directed matrices
module tb_drain_m;

  logic         clk = 1'b0;
  logic         rst, start, ovf_in, m_ready;
  logic [199:0] mat_in;
  logic [1:0]   size;
  logic         m_valid, busy, done, ovf_out;
  logic [4:0]   m_addr;
  logic [7:0]   m_data;

  always #5 clk = ~clk;

  drain_m dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mat_in  (mat_in),
    .ovf_in  (ovf_in),
    .size    (size),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_addr  (m_addr),
    .m_data  (m_data),
    .busy    (busy),
    .done    (done),
    .ovf_out (ovf_out)
  );

  int         total = 0;
  int         bad = 0;
  int         n_xfer = 0;
  int         done_seen = 0;
  logic [4:0] qa[$];
  logic [7:0] qd[$];
  logic       stall_prev = 1'b0;
  logic [4:0] pa;
  logic [7:0] pd;
  logic [7:0] el[5][5];

  always @(negedge clk) begin
    logic [4:0] ea;
    logic [7:0] ed;
    if (m_valid && stall_prev) begin
      total++;
      if (m_addr !== pa || m_data !== pd) begin
        bad++;
        $display("FAIL stall_hold got addr=%0d data=%02h want addr=%0d data=%02h", m_addr, m_data, pa, pd);
      end
    end
    if (m_valid && m_ready) begin
      n_xfer++;
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL unexpected_xfer got addr=%0d data=%02h want none", m_addr, m_data);
      end else begin
        ea = qa.pop_front();
        ed = qd.pop_front();
        if (m_addr !== ea || m_data !== ed) begin
          bad++;
          $display("FAIL xfer got addr=%0d data=%02h want addr=%0d data=%02h", m_addr, m_data, ea, ed);
        end
      end
    end
    stall_prev = m_valid && !m_ready;
    pa = m_addr;
    pd = m_data;
    if (done) done_seen++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Packs el[][] using the bit-slice formula (0,0) at [199:192].
  task automatic build_mat;
    mat_in = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        mat_in[199 - 40*r - 8*c -: 8] = el[r][c];
  endtask

  task automatic push_exp(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        qa.push_back(5'(r*5 + c));
        qd.push_back(el[r][c]);
      end
  endtask

  // Pulses start and runs until done; ready pattern is a 4-bit cyclic mask (bit0 first).
  task automatic run_drain(input int n, input logic [3:0] pat, input bit chk_lat, input string nm);
    int cyc;
    n_xfer = 0;
    done_seen = 0;
    m_ready = pat[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      m_ready = pat[cyc % 4];
      tick();
      cyc++;
    end
    m_ready = 1'b1;
    chk({nm, "_done_seen"}, 32'(done), 32'd1);
    if (chk_lat) chk({nm, "_done_latency"}, 32'(cyc), 32'(n*n + 1));
    chk({nm, "_xfer_count"}, 32'(n_xfer), 32'(n*n));
    chk({nm, "_queue_empty"}, 32'(qa.size()), 32'd0);
    tick();
    chk({nm, "_idle_after_done"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; ovf_in = 1'b0; m_ready = 1'b1; size = 2'b00; mat_in = '0;
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) el[r][c] = 8'h00;
    tick(); tick();
    chk("reset_outputs", {20'd0, m_valid, busy, done, ovf_out, m_addr, 3'd0}, 32'd0);
    chk("reset_data", 32'(m_data), 32'd0);
    rst = 1'b1;
    tick();

    // 2x2 small drain
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) el[r][c] = 8'(r*5 + c + 1);
    build_mat();
    size = 2'b00;
    push_exp(2);
    run_drain(2, 4'b1111, 1'b1, "t2x2");

    // 5x5 signed ramp -12..12
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) el[r][c] = 8'(r*5 + c - 12);
    build_mat();
    size = 2'b11;
    push_exp(5);
    run_drain(5, 4'b1111, 1'b1, "t5x5");

    // 3x3 with ready toggling 1,0,0,1
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) el[r][c] = 8'(r*16 + c + 8'h30);
    build_mat();
    size = 2'b01;
    push_exp(3);
    run_drain(3, 4'b1001, 1'b0, "t3x3_stall");

    // overflow capture and mid-drain start ignored
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) el[r][c] = 8'(8'h80 + r*8 + c);
    build_mat();
    size = 2'b01;
    ovf_in = 1'b1;
    push_exp(3);
    n_xfer = 0; done_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ovf_in = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      if (cyc == 3) begin
        mat_in = {25{8'hAA}};
        size = 2'b11;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("ovf_done_latency", 32'(cyc), 32'd10);
    chk("ovf_xfer_count", 32'(n_xfer), 32'd9);
    chk("ovf_out_latched", 32'(ovf_out), 32'd1);
    tick(); tick();
    chk("ovf_out_held", 32'(ovf_out), 32'd1);
    chk("ovf_no_restart", 32'(busy), 32'd0);

    // reset during transfer 3 of a 4x4 drain
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) el[r][c] = 8'(8'h40 + r*5 + c);
    build_mat();
    size = 2'b10;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      qa.push_back(5'(i));
      qd.push_back(el[0][i]);
    end
    n_xfer = 0; done_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("abort_valid_busy", {30'd0, m_valid, busy}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("abort_xfer_count", 32'(n_xfer), 32'd3);
    chk("abort_addr_cleared", 32'(m_addr), 32'd0);
    push_exp(4);
    run_drain(4, 4'b1111, 1'b1, "t4x4_after_abort");
    chk("ovf_cleared_by_new_start", 32'(ovf_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
